ram_pipelined_parity: RTL and testbench

Parametrised successor to the single-port parity RAM: a synchronous single-port memory with byte-lane write enables, per-lane stored parity, optional address and output pipeline registers (DSP48A1-style register-or-bypass selection), a selectable read-during-write mode, and parity-error detection with a sticky error counter. It serves as the shared coefficient/sample store for the DSP datapath and as the drop-in replacement for the fixed 16x1024 RAM.

---
 rtl/ram_pipelined_parity.sv | 232 +++++++++++++++++++++++
 tb/tb_ram_pipelined_parity.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_pipelined_parity.sv
// ram_pipelined_parity
//   Single-port synchronous RAM with byte-lane write enables and per-lane
//   even parity stored alongside each lane. An optional command/address
//   register (ADDR_REG) and an optional output register (DOUT_REG) can each be
//   built in or bypassed. The read-during-write behaviour is set by WRITE_MODE.
//   Reads are checked for parity errors, and those errors are logged with a
//   sticky address and a saturating count.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   blk_select  qualifies wr_en / rd_en
//   addr_en     address register load enable (ADDR_REG=1)
//   wr_en       write request
//   rd_en       read request
//   be          byte-lane write enables
//   err_inject  store inverted lane-0 parity on a write
//   addr        word address
//   din         write data
//   dout_en     output register load enable (DOUT_REG=1)
//   dout        read data
//   parity_out  stored parity of the read word
//   rd_valid    single-cycle pulse, dout/parity_out/parity_err valid
//   parity_err  recomputed parity differs from stored parity
//   err_addr    address of most recent erroneous read
//   err_count   saturating count of erroneous reads
module ram_pipelined_parity #(
   parameter int DATA_W     = 16,
   parameter int BYTE_W     = 8,
   parameter int DEPTH      = 1024,
   parameter int ADDR_W     = 10,
   parameter int ADDR_REG   = 1,
   parameter int DOUT_REG   = 1,
   parameter int WRITE_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       blk_select,
   input  logic                       addr_en,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic [DATA_W/BYTE_W-1:0]   be,
   input  logic                       err_inject,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          din,
   input  logic                       dout_en,
   output logic [DATA_W-1:0]          dout,
   output logic [DATA_W/BYTE_W-1:0]   parity_out,
   output logic                       rd_valid,
   output logic                       parity_err,
   output logic [ADDR_W-1:0]          err_addr,
   output logic [7:0]                 err_count
);

   localparam int NLANES = DATA_W / BYTE_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   function automatic logic par_bad(input logic [DATA_W-1:0] d,
                                    input logic [NLANES-1:0] p);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NLANES; i++)
         bad = bad | ((^d[i*BYTE_W +: BYTE_W]) != p[i]);
      return bad;
   endfunction

   // command stage outputs
   logic                c_wr, c_rd, c_blk, c_inj;
   logic [NLANES-1:0]   c_be;
   logic [DATA_W-1:0]   c_din;
   logic [ADDR_W-1:0]   c_addr;

   if (ADDR_REG != 0) begin : g_cmd_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            c_wr   <= 1'b0;
            c_rd   <= 1'b0;
            c_blk  <= 1'b0;
            c_inj  <= 1'b0;
            c_be   <= '0;
            c_din  <= '0;
            c_addr <= '0;
         end else begin
            c_wr  <= wr_en;
            c_rd  <= rd_en;
            c_blk <= blk_select;
            c_inj <= err_inject;
            c_be  <= be;
            c_din <= din;
            if (addr_en)
               c_addr <= addr;
         end
      end
   end else begin : g_cmd_bypass
      assign c_wr   = wr_en;
      assign c_rd   = rd_en;
      assign c_blk  = blk_select;
      assign c_inj  = err_inject;
      assign c_be   = be;
      assign c_din  = din;
      assign c_addr = addr;
   end

   // array stage
   logic [DATA_W-1:0]   mem     [DEPTH];
   logic [NLANES-1:0]   mem_par [DEPTH];

   logic                in_range, do_wr, do_rd;
   logic [DATA_W-1:0]   rd_word, merged, n_data;
   logic [NLANES-1:0]   rd_par, wr_par, merged_par, n_par;
   logic                n_err;

   assign in_range = ({1'b0, c_addr} < DEPTH_L);
   assign do_wr    = c_blk & c_wr & in_range;
   assign do_rd    = c_blk & c_rd;
   assign rd_word  = mem[c_addr];
   assign rd_par   = mem_par[c_addr];

   // new lane parity, and the word as it looks after this write lands
   always_comb begin
      wr_par     = '0;
      merged     = rd_word;
      merged_par = rd_par;
      for (int i = 0; i < NLANES; i++) begin
         wr_par[i] = ^c_din[i*BYTE_W +: BYTE_W];
         if (i == 0)
            wr_par[i] = wr_par[i] ^ c_inj;
         if (c_be[i]) begin
            merged[i*BYTE_W +: BYTE_W] = c_din[i*BYTE_W +: BYTE_W];
            merged_par[i]              = wr_par[i];
         end
      end
   end

   // READ_FIRST and NO_CHANGE both return the pre-write word on a collision
   always_comb begin
      n_data = '0;
      n_par  = '0;
      if (in_range) begin
         if (WRITE_MODE == 1 && do_wr) begin
            n_data = merged;
            n_par  = merged_par;
         end else begin
            n_data = rd_word;
            n_par  = rd_par;
         end
      end
   end

   assign n_err = par_bad(n_data, n_par);

   // a write landing on a reset edge is dropped
   always_ff @(posedge clk) begin
      if (do_wr && !rst) begin
         for (int i = 0; i < NLANES; i++) begin
            if (c_be[i]) begin
               mem[c_addr][i*BYTE_W +: BYTE_W] <= c_din[i*BYTE_W +: BYTE_W];
               mem_par[c_addr][i]              <= wr_par[i];
            end
         end
      end
   end

   // array output register; holds its contents when no read occurs
   logic [DATA_W-1:0]   a_data;
   logic [NLANES-1:0]   a_par;
   logic                a_vld;
   logic [ADDR_W-1:0]   a_addr;
   logic                a_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_data <= '0;
         a_par  <= '0;
         a_vld  <= 1'b0;
         a_addr <= '0;
      end else begin
         a_vld <= do_rd;
         if (do_rd) begin
            a_data <= n_data;
            a_par  <= n_par;
            a_addr <= c_addr;
         end
      end
   end

   assign a_err = par_bad(a_data, a_par);

   // output stage and the error-log source aligned with rd_valid
   logic                log_v;
   logic [ADDR_W-1:0]   log_a;

   if (DOUT_REG != 0) begin : g_dout_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            dout       <= '0;
            parity_out <= '0;
            parity_err <= 1'b0;
            rd_valid   <= 1'b0;
         end else begin
            rd_valid <= a_vld & dout_en;
            if (dout_en) begin
               dout       <= a_data;
               parity_out <= a_par;
               parity_err <= a_err;
            end
         end
      end
      assign log_v = a_vld & dout_en & a_err;
      assign log_a = a_addr;
   end else begin : g_dout_bypass
      assign dout       = a_data;
      assign parity_out = a_par;
      assign parity_err = a_err;
      assign rd_valid   = a_vld;
      // log on the edge that makes the read visible
      assign log_v      = do_rd & n_err;
      assign log_a      = c_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_addr  <= '0;
         err_count <= 8'd0;
      end else if (log_v) begin
         err_addr <= log_a;
         if (err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_ram_pipelined_parity.sv
// Bench for ram_pipelined_parity. Four builds share one stimulus stream:
// u0 defaults (READ_FIRST), u1 WRITE_FIRST, u2 NO_CHANGE,
// u3 ADDR_REG=0/DOUT_REG=0 with DEPTH=1000 so out-of-range reads are reachable.
module tb_ram_pipelined_parity;
   localparam int NI   = 4;
   localparam int MAXC = 2048;

   logic clk = 1'b0;
   logic rst, blk, aen, wr, rd, inj, den;
   logic [1:0]  be;
   logic [9:0]  addr;
   logic [15:0] din;

   logic [15:0] dout_w [NI];
   logic [1:0]  par_w  [NI];
   logic        rv_w   [NI];
   logic        perr_w [NI];
   logic [9:0]  eadr_w [NI];
   logic [7:0]  ecnt_w [NI];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_pipelined_parity u0 (
      .clk(clk), .rst(rst), .blk_select(blk), .addr_en(aen), .wr_en(wr), .rd_en(rd),
      .be(be), .err_inject(inj), .addr(addr), .din(din), .dout_en(den),
      .dout(dout_w[0]), .parity_out(par_w[0]), .rd_valid(rv_w[0]), .parity_err(perr_w[0]),
      .err_addr(eadr_w[0]), .err_count(ecnt_w[0]));

   ram_pipelined_parity #(.WRITE_MODE(1)) u1 (
      .clk(clk), .rst(rst), .blk_select(blk), .addr_en(aen), .wr_en(wr), .rd_en(rd),
      .be(be), .err_inject(inj), .addr(addr), .din(din), .dout_en(den),
      .dout(dout_w[1]), .parity_out(par_w[1]), .rd_valid(rv_w[1]), .parity_err(perr_w[1]),
      .err_addr(eadr_w[1]), .err_count(ecnt_w[1]));

   ram_pipelined_parity #(.WRITE_MODE(2)) u2 (
      .clk(clk), .rst(rst), .blk_select(blk), .addr_en(aen), .wr_en(wr), .rd_en(rd),
      .be(be), .err_inject(inj), .addr(addr), .din(din), .dout_en(den),
      .dout(dout_w[2]), .parity_out(par_w[2]), .rd_valid(rv_w[2]), .parity_err(perr_w[2]),
      .err_addr(eadr_w[2]), .err_count(ecnt_w[2]));

   ram_pipelined_parity #(.ADDR_REG(0), .DOUT_REG(0), .DEPTH(1000)) u3 (
      .clk(clk), .rst(rst), .blk_select(blk), .addr_en(aen), .wr_en(wr), .rd_en(rd),
      .be(be), .err_inject(inj), .addr(addr), .din(din), .dout_en(den),
      .dout(dout_w[3]), .parity_out(par_w[3]), .rd_valid(rv_w[3]), .parity_err(perr_w[3]),
      .err_addr(eadr_w[3]), .err_count(ecnt_w[3]));

   function automatic int ar_of(input int k);  return (k == 3) ? 0 : 1;    endfunction
   function automatic int dr_of(input int k);  return (k == 3) ? 0 : 1;    endfunction
   function automatic int wm_of(input int k);  return (k == 1) ? 1 : ((k == 2) ? 2 : 0); endfunction
   function automatic int dep_of(input int k); return (k == 3) ? 1000 : 1024; endfunction

   // ---------------- behavioural model ----------------
   // Inputs seen at each rising edge are logged; an op issued at edge c acts on
   // the array at edge c+AR and shows at the output after edge c+AR+DR.
   logic        h_rst [MAXC], h_blk [MAXC], h_wr [MAXC], h_rd [MAXC];
   logic        h_inj [MAXC], h_den [MAXC], h_aen [MAXC];
   logic [1:0]  h_be  [MAXC];
   logic [9:0]  h_addr[MAXC];
   logic [15:0] h_din [MAXC];

   logic [15:0] m_mem  [NI][1024];
   logic [1:0]  m_par  [NI][1024];
   logic [9:0]  m_areg [NI];
   logic [9:0]  m_ea   [NI][MAXC];
   logic        p_v    [NI][MAXC];
   logic [15:0] p_d    [NI][MAXC];
   logic [1:0]  p_p    [NI][MAXC];
   logic        p_e    [NI][MAXC];
   logic [9:0]  p_a    [NI][MAXC];
   int          m_cnt  [NI];
   logic [9:0]  m_erra [NI];

   task automatic model_edge(input int k, input int e,
                             output logic xv, output logic [15:0] xd,
                             output logic [1:0] xp, output logic xe);
      int c, o;
      logic ok, inr;
      logic [9:0]  a;
      logic [15:0] oldw, neww;
      logic [1:0]  oldp, newp;
      if (ar_of(k) != 0) begin
         if (h_rst[e])      m_areg[k] = 10'd0;
         else if (h_aen[e]) m_areg[k] = h_addr[e];
         m_ea[k][e] = m_areg[k];
      end else begin
         m_ea[k][e] = h_addr[e];
      end
      p_v[k][e] = 1'b0; p_d[k][e] = '0; p_p[k][e] = '0; p_e[k][e] = 1'b0; p_a[k][e] = '0;
      c  = e - ar_of(k);
      ok = (c >= 0);
      for (int j = c; j <= e; j++)
         if (j >= 0 && h_rst[j]) ok = 1'b0;
      if (ok && h_blk[c]) begin
         a    = m_ea[k][c];
         inr  = (int'(a) < dep_of(k));
         oldw = m_mem[k][a];
         oldp = m_par[k][a];
         neww = oldw;
         newp = oldp;
         if (h_be[c][0]) begin
            neww[7:0] = h_din[c][7:0];
            newp[0]   = (^h_din[c][7:0]) ^ h_inj[c];
         end
         if (h_be[c][1]) begin
            neww[15:8] = h_din[c][15:8];
            newp[1]    = ^h_din[c][15:8];
         end
         if (h_rd[c]) begin
            p_v[k][e] = 1'b1;
            p_a[k][e] = a;
            if (!inr) begin
               p_d[k][e] = 16'h0000; p_p[k][e] = 2'b00;
            end else if (wm_of(k) == 1 && h_wr[c]) begin
               p_d[k][e] = neww; p_p[k][e] = newp;
            end else begin
               p_d[k][e] = oldw; p_p[k][e] = oldp;
            end
            p_e[k][e] = ((^p_d[k][e][7:0]) != p_p[k][e][0]) || ((^p_d[k][e][15:8]) != p_p[k][e][1]);
         end
         if (h_wr[c] && inr) begin
            m_mem[k][a] = neww;
            m_par[k][a] = newp;
         end
      end
      o  = e - dr_of(k);
      xv = 1'b0; xd = '0; xp = '0; xe = 1'b0;
      if (o >= 0 && p_v[k][o] && !h_rst[e] && (dr_of(k) == 0 || h_den[e])) begin
         xv = 1'b1; xd = p_d[k][o]; xp = p_p[k][o]; xe = p_e[k][o];
      end
      if (h_rst[e]) begin
         m_cnt[k] = 0; m_erra[k] = 10'd0;
      end else if (xv && xe) begin
         m_erra[k] = p_a[k][o];
         if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
      end
   endtask

   // compare process: every edge, every build
   initial begin : compare
      int e_n;
      logic xv, xe;
      logic [15:0] xd;
      logic [1:0]  xp;
      e_n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (e_n < MAXC) begin
            h_rst[e_n] = rst;  h_blk[e_n] = blk; h_wr[e_n] = wr;   h_rd[e_n] = rd;
            h_inj[e_n] = inj;  h_den[e_n] = den; h_aen[e_n] = aen; h_be[e_n] = be;
            h_addr[e_n] = addr; h_din[e_n] = din;
            for (int k = 0; k < NI; k++) begin
               model_edge(k, e_n, xv, xd, xp, xe);
               checks++;
               if (rv_w[k] !== xv) begin
                  failures++;
                  $display("FAIL rd_valid u%0d edge %0d got %b want %b", k, e_n, rv_w[k], xv);
               end
               if (xv) begin
                  checks++;
                  if (dout_w[k] !== xd || par_w[k] !== xp || perr_w[k] !== xe) begin
                     failures++;
                     $display("FAIL read u%0d edge %0d got d=%h p=%b e=%b want d=%h p=%b e=%b",
                              k, e_n, dout_w[k], par_w[k], perr_w[k], xd, xp, xe);
                  end
               end
               checks++;
               if (ecnt_w[k] !== 8'(m_cnt[k]) || eadr_w[k] !== m_erra[k]) begin
                  failures++;
                  $display("FAIL errlog u%0d edge %0d got cnt=%0d addr=%0d want cnt=%0d addr=%0d",
                           k, e_n, ecnt_w[k], eadr_w[k], m_cnt[k], m_erra[k]);
               end
            end
            e_n++;
         end
      end
   end

   // ---------------- directed stimulus + literal pins ----------------
   task automatic lcheck(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic op(input logic b, input logic w, input logic r, input logic [9:0] a,
                     input logic [15:0] d, input logic [1:0] bb, input logic ij);
      blk = b; wr = w; rd = r; addr = a; din = d; be = bb; inj = ij;
   endtask

   task automatic idle();
      wr = 1'b0; rd = 1'b0; inj = 1'b0;
   endtask

   initial begin : stim
      rst = 1'b1; blk = 1'b0; aen = 1'b1; wr = 1'b0; rd = 1'b0; inj = 1'b0;
      den = 1'b1; be = 2'b00; addr = '0; din = '0;
      tick(3);
      rst = 1'b0;
      lcheck("reset dout", 32'(dout_w[0]), 32'h0);
      lcheck("reset rd_valid", 32'(rv_w[0]), 32'h0);
      lcheck("reset err_count", 32'(ecnt_w[0]), 32'h0);

      // basic write/read and latency
      op(1, 1, 0, 10'd5, 16'hA5C3, 2'b11, 0); tick(1);
      op(1, 0, 1, 10'd5, 16'h0000, 2'b00, 0); tick(1);
      idle();
      lcheck("lat1 u3 rd_valid", 32'(rv_w[3]), 32'h1);
      lcheck("lat1 u3 dout", 32'(dout_w[3]), 32'hA5C3);
      lcheck("lat u0 early1", 32'(rv_w[0]), 32'h0);
      tick(1);
      lcheck("lat u0 early2", 32'(rv_w[0]), 32'h0);
      tick(1);
      lcheck("lat3 u0 rd_valid", 32'(rv_w[0]), 32'h1);
      lcheck("basic u0 dout", 32'(dout_w[0]), 32'hA5C3);
      lcheck("basic u0 parity", 32'(par_w[0]), 32'h0);
      lcheck("basic u0 perr", 32'(perr_w[0]), 32'h0);

      // partial write
      op(1, 1, 0, 10'd7, 16'h1234, 2'b11, 0); tick(1);
      op(1, 1, 0, 10'd7, 16'hFFFF, 2'b01, 0); tick(1);
      op(1, 0, 1, 10'd7, 16'h0000, 2'b00, 0); tick(1);
      idle(); tick(2);
      lcheck("partial dout", 32'(dout_w[0]), 32'h12FF);
      lcheck("partial parity", 32'(par_w[0]), 32'h0);

      // simultaneous write and read on addr 3
      op(1, 1, 0, 10'd3, 16'h0001, 2'b11, 0); tick(1);
      op(1, 1, 1, 10'd3, 16'h00FF, 2'b11, 0); tick(1);
      idle();
      lcheck("rdw u3 read_first", 32'(dout_w[3]), 32'h0001);
      tick(2);
      lcheck("rdw read_first", 32'(dout_w[0]), 32'h0001);
      lcheck("rdw write_first", 32'(dout_w[1]), 32'h00FF);
      lcheck("rdw no_change", 32'(dout_w[2]), 32'h0001);
      op(1, 0, 1, 10'd3, 16'h0000, 2'b00, 0); tick(1);
      idle(); tick(2);
      lcheck("rdw after", 32'(dout_w[0]), 32'h00FF);

      // blk_select=0 blocks a write
      op(0, 1, 0, 10'd5, 16'hDEAD, 2'b11, 0); tick(1);
      op(1, 0, 1, 10'd5, 16'h0000, 2'b00, 0); tick(1);
      idle();
      lcheck("blk u3 dout", 32'(dout_w[3]), 32'hA5C3);
      tick(2);
      lcheck("blk u0 dout", 32'(dout_w[0]), 32'hA5C3);

      // addr_en=0 holds the registered address
      op(1, 0, 1, 10'd5, 16'h0000, 2'b00, 0); tick(1);
      aen = 1'b0; addr = 10'd7; tick(1);
      aen = 1'b1; idle();
      lcheck("aen u3 dout", 32'(dout_w[3]), 32'h12FF);
      tick(2);
      lcheck("aen u0 held addr", 32'(dout_w[0]), 32'hA5C3);

      // read dropped when dout_en=0 as it reaches the output
      op(1, 0, 1, 10'd5, 16'h0000, 2'b00, 0); tick(1);
      idle(); tick(1);
      den = 1'b0; tick(1);
      den = 1'b1;
      lcheck("drop rd_valid", 32'(rv_w[0]), 32'h0);
      tick(1);
      lcheck("drop rd_valid late", 32'(rv_w[0]), 32'h0);

      // out-of-range on the DEPTH=1000 build
      op(1, 1, 0, 10'd1000, 16'h5A5A, 2'b11, 0); tick(1);
      op(1, 0, 1, 10'd1000, 16'h0000, 2'b00, 0); tick(1);
      idle();
      lcheck("oor u3 rd_valid", 32'(rv_w[3]), 32'h1);
      lcheck("oor u3 dout", 32'(dout_w[3]), 32'h0);
      tick(2);
      lcheck("inrange u0 dout", 32'(dout_w[0]), 32'h5A5A);

      // injected parity error, read 300 times
      op(1, 1, 0, 10'd9, 16'h0000, 2'b11, 1); tick(1);
      op(1, 0, 1, 10'd9, 16'h0000, 2'b00, 0);
      tick(300);
      idle(); tick(3);
      lcheck("err perr", 32'(perr_w[0]), 32'h1);
      lcheck("err parity_out", 32'(par_w[0]), 32'h1);
      lcheck("err_count sat u0", 32'(ecnt_w[0]), 32'd255);
      lcheck("err_addr u0", 32'(eadr_w[0]), 32'd9);
      lcheck("err_count sat u3", 32'(ecnt_w[3]), 32'd255);

      // reset one cycle after a read
      op(1, 0, 1, 10'd5, 16'h0000, 2'b00, 0); tick(1);
      idle(); rst = 1'b1; tick(1);
      rst = 1'b0;
      lcheck("rst rd_valid", 32'(rv_w[0]), 32'h0);
      lcheck("rst dout", 32'(dout_w[0]), 32'h0);
      lcheck("rst err_count", 32'(ecnt_w[0]), 32'h0);
      lcheck("rst err_addr", 32'(eadr_w[0]), 32'h0);
      tick(3);
      op(1, 0, 1, 10'd5, 16'h0000, 2'b00, 0); tick(1);
      idle(); tick(2);
      lcheck("post-rst dout", 32'(dout_w[0]), 32'hA5C3);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
